// File: rtl/switch_led_pio_pkg.sv
// Shared constants for the switch/LED PIO: register word addresses and bus widths.
package switch_led_pkg;

    localparam int DATA_W = 32;
    localparam int PWM_W  = 8;

    localparam logic [2:0] ADDR_DATA         = 3'd0;
    localparam logic [2:0] ADDR_LED          = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
    localparam logic [2:0] ADDR_EDGE_SEL     = 3'd4;
    localparam logic [2:0] ADDR_PWM          = 3'd5;

endpackage

// File: rtl/switch_led_pio_if.sv
// Avalon-MM slave bus bundle for the switch/LED PIO (no waitrequest, fixed read latency).
interface switch_led_pio_if;

    logic [2:0]                        avs_address;
    logic                              avs_read;
    logic                              avs_write;
    logic [switch_led_pkg::DATA_W-1:0] avs_writedata;
    logic [switch_led_pkg::DATA_W-1:0] avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );

endinterface

// File: rtl/switch_led_pio_debounce.sv
// One switch channel: 2-flop synchroniser, stability counter, debounced level and edge pulses.
module switch_debounce #(
    parameter  int DEBOUNCE_CYCLES = 50000,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_async,
    output logic sw_state,
    output logic rise,
    output logic fall
);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            cnt      <= '0;
            sw_state <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            sync_p0 <= sw_async;
            sync_p1 <= sync_p0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            // Any return to the accepted level restarts the stability window.
            if (sync_p1 == sw_state) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                sw_state <= sync_p1;
                cnt      <= '0;
                rise     <= sync_p1;
                fall     <= ~sync_p1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/switch_led_pio.sv
// Debounced switch inputs with edge capture/IRQ and LED output register on Avalon-MM.
// Optional LED brightness PWM on register 5 when SWITCH_LED_PIO_PWM_EN is defined.
module switch_led_pio
    import switch_led_pkg::*;
#(
    parameter int NUM_SW          = 10,
    parameter int NUM_LED         = 10,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    switch_led_pio_if.slave    avs,
    input  logic [NUM_SW-1:0]  sw_in,
    output logic [NUM_LED-1:0] led_out,
    output logic               irq
);

    logic [NUM_SW-1:0]  sw_state;
    logic [NUM_SW-1:0]  sw_rise;
    logic [NUM_SW-1:0]  sw_fall;
    logic [NUM_LED-1:0] led_reg;
    logic [NUM_LED-1:0] led_next;
    logic [NUM_SW-1:0]  irq_mask;
    logic [NUM_SW-1:0]  edge_sel;
    logic [NUM_SW-1:0]  edge_cap;
    logic [NUM_SW-1:0]  edge_set;
    logic [NUM_SW-1:0]  edge_clr;
    logic [DATA_W-1:0]  rd_mux;
    logic               wr_led;
    logic               wr_mask;
    logic               wr_cap;
    logic               wr_sel;
    logic               unused_wdata;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
            .clk      (clk_clk),
            .rst_n    (reset_reset_n),
            .sw_async (sw_in[i]),
            .sw_state (sw_state[i]),
            .rise     (sw_rise[i]),
            .fall     (sw_fall[i])
        );
    end

    assign wr_led  = avs.avs_write && (avs.avs_address == ADDR_LED);
    assign wr_mask = avs.avs_write && (avs.avs_address == ADDR_IRQ_MASK);
    assign wr_cap  = avs.avs_write && (avs.avs_address == ADDR_EDGE_CAPTURE);
    assign wr_sel  = avs.avs_write && (avs.avs_address == ADDR_EDGE_SEL);

    assign unused_wdata = &{1'b0, avs.avs_writedata};

    // New edges are OR-ed in after the W1C so a coincident clear cannot drop them.
    assign edge_set = (sw_rise & ~edge_sel) | (sw_fall & edge_sel);
    assign edge_clr = wr_cap ? avs.avs_writedata[NUM_SW-1:0] : '0;

`ifdef SWITCH_LED_PIO_PWM_EN
    logic [PWM_W-1:0] pwm_level;
    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pwm_level <= '1;
            pwm_cnt   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            if (avs.avs_write && (avs.avs_address == ADDR_PWM))
                pwm_level <= avs.avs_writedata[PWM_W-1:0];
        end
    end

    assign led_next = led_reg & {NUM_LED{pwm_cnt < pwm_level}};
`else
    assign led_next = led_reg;
`endif

    always_comb begin
        rd_mux = '0;
        case (avs.avs_address)
            ADDR_DATA:         rd_mux[NUM_SW-1:0]  = sw_state;
            ADDR_LED:          rd_mux[NUM_LED-1:0] = led_reg;
            ADDR_IRQ_MASK:     rd_mux[NUM_SW-1:0]  = irq_mask;
            ADDR_EDGE_CAPTURE: rd_mux[NUM_SW-1:0]  = edge_cap;
            ADDR_EDGE_SEL:     rd_mux[NUM_SW-1:0]  = edge_sel;
`ifdef SWITCH_LED_PIO_PWM_EN
            ADDR_PWM:          rd_mux[PWM_W-1:0]   = pwm_level;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            led_reg          <= '0;
            irq_mask         <= '0;
            edge_sel         <= '0;
            edge_cap         <= '0;
            irq              <= 1'b0;
            led_out          <= '0;
            avs.avs_readdata <= '0;
        end else begin
            if (wr_led)  led_reg  <= avs.avs_writedata[NUM_LED-1:0];
            if (wr_mask) irq_mask <= avs.avs_writedata[NUM_SW-1:0];
            if (wr_sel)  edge_sel <= avs.avs_writedata[NUM_SW-1:0];
            edge_cap <= (edge_cap & ~edge_clr) | edge_set;
            irq      <= |(edge_cap & irq_mask);
            led_out  <= led_next;
            // Read data is sampled before this edge's writes land, so read-during-write sees the old value.
            if (avs.avs_read) avs.avs_readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_switch_led_pio.sv
// Directed bench for switch_led_pio with a short debounce window (8 cycles).
module tb_switch_led_pio;
    import switch_led_pkg::*;

    localparam int NUM_SW  = 10;
    localparam int NUM_LED = 10;
    localparam int DEB     = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_SW-1:0]  sw_in;
    logic [NUM_LED-1:0] led_out;
    logic               irq;
    logic [31:0]        rd;
    int                 n_checks = 0;
    int                 n_fail   = 0;
    int                 hi_cnt;

    switch_led_pio_if bus();

    switch_led_pio #(
        .NUM_SW          (NUM_SW),
        .NUM_LED         (NUM_LED),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .avs           (bus),
        .sw_in         (sw_in),
        .led_out       (led_out),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        bus.avs_address   = addr;
        bus.avs_writedata = data;
        bus.avs_write     = 1'b1;
        step();
        bus.avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
        bus.avs_address = addr;
        bus.avs_read    = 1'b1;
        step();
        bus.avs_read    = 1'b0;
        data            = bus.avs_readdata;
    endtask

    task automatic read_check(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(addr, d);
        check(tag, d, exp);
    endtask

    initial begin
        rst_n             = 1'b0;
        sw_in             = '0;
        bus.avs_address   = 3'd0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = 32'h0;

        // Reset held while switches toggle
        step(2);
        sw_in = 10'h3FF;
        step(3);
        sw_in = '0;
        step(2);
        check("reset_led_out", 32'(led_out), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_readdata", bus.avs_readdata, 32'h0);
        rst_n = 1'b1;
        step(12);
        read_check("data_after_reset", ADDR_DATA, 32'h0);

        // Bounce rejection: three 5-cycle pulses
        repeat (3) begin
            sw_in[0] = 1'b1;
            step(5);
            sw_in[0] = 1'b0;
            step(5);
        end
        step(4);
        read_check("bounce_rejected", ADDR_DATA, 32'h0);

        // Clean step: state updates on edge 10, visible through readdata on edge 11
        sw_in[0]        = 1'b1;
        bus.avs_address = ADDR_DATA;
        bus.avs_read    = 1'b1;
        step(10);
        check("latency_edge10", bus.avs_readdata, 32'h0);
        step(1);
        check("latency_edge11", bus.avs_readdata, 32'h1);
        bus.avs_read = 1'b0;
        step(2);
        read_check("cap_rise0", ADDR_EDGE_CAPTURE, 32'h001);
        check("irq_masked_off", 32'(irq), 32'h0);
        bus_write(ADDR_EDGE_CAPTURE, 32'h3FF);
        read_check("cap_cleared", ADDR_EDGE_CAPTURE, 32'h0);

        // Interrupt flow
        bus_write(ADDR_IRQ_MASK, 32'h002);
        sw_in[1] = 1'b1;
        step(14);
        read_check("cap_rise1", ADDR_EDGE_CAPTURE, 32'h002);
        check("irq_set", 32'(irq), 32'h1);
        bus_write(ADDR_EDGE_CAPTURE, 32'h002);
        check("irq_on_clear_edge", 32'(irq), 32'h1);
        step(1);
        check("irq_cleared", 32'(irq), 32'h0);
        sw_in[2] = 1'b1;
        step(14);
        read_check("cap_rise2", ADDR_EDGE_CAPTURE, 32'h004);
        check("irq_unmasked_bit", 32'(irq), 32'h0);
        bus_write(ADDR_EDGE_CAPTURE, 32'h3FF);

        // Edge select on channel 0
        bus_write(ADDR_EDGE_SEL, 32'h001);
        read_check("edge_sel_rb", ADDR_EDGE_SEL, 32'h001);
        sw_in[0] = 1'b0;
        step(14);
        read_check("cap_fall0", ADDR_EDGE_CAPTURE, 32'h001);
        bus_write(ADDR_EDGE_CAPTURE, 32'h001);
        sw_in[0] = 1'b1;
        step(14);
        read_check("cap_rise0_ignored", ADDR_EDGE_CAPTURE, 32'h0);

        // W1C on the same edge that captures a new fall
        sw_in[0] = 1'b0;
        step(10);
        bus_write(ADDR_EDGE_CAPTURE, 32'h001);
        read_check("collision_set_wins", ADDR_EDGE_CAPTURE, 32'h001);
        bus_write(ADDR_EDGE_CAPTURE, 32'h001);
        read_check("w1c_clears", ADDR_EDGE_CAPTURE, 32'h0);

        // LED path
        bus_write(ADDR_LED, 32'h2A5);
`ifndef SWITCH_LED_PIO_PWM_EN
        check("led_out_before", 32'(led_out), 32'h0);
        step(1);
        check("led_out_after", 32'(led_out), 32'h2A5);
`endif
        read_check("led_readback", ADDR_LED, 32'h0000_02A5);
        bus_write(ADDR_LED, 32'hFFFF_FFFF);
        read_check("led_upper_zero", ADDR_LED, 32'h3FF);

        // Simultaneous read and write to LED returns the old value
        bus.avs_address   = ADDR_LED;
        bus.avs_writedata = 32'h155;
        bus.avs_read      = 1'b1;
        bus.avs_write     = 1'b1;
        step();
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        check("rw_same_old", bus.avs_readdata, 32'h3FF);
        read_check("rw_new_value", ADDR_LED, 32'h155);
        step(3);
        check("readdata_hold", bus.avs_readdata, 32'h155);

        // Unused addresses and other readbacks
        bus_write(3'd6, 32'hFFFF_FFFF);
        read_check("addr6_zero", 3'd6, 32'h0);
        read_check("addr7_zero", 3'd7, 32'h0);
        read_check("mask_rb", ADDR_IRQ_MASK, 32'h002);
        read_check("data_levels", ADDR_DATA, 32'h006);

`ifdef SWITCH_LED_PIO_PWM_EN
        read_check("pwm_reset", ADDR_PWM, 32'hFF);
        bus_write(ADDR_PWM, 32'h40);
        read_check("pwm_rb", ADDR_PWM, 32'h40);
        step(2);
        hi_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            if (led_out[0]) hi_cnt++;
            step();
        end
        check("pwm_duty_64", 32'(hi_cnt), 32'd64);
        bus_write(ADDR_PWM, 32'h0);
        step(2);
        hi_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            if (led_out != '0) hi_cnt++;
            step();
        end
        check("pwm_duty_0", 32'(hi_cnt), 32'd0);
`else
        bus_write(ADDR_PWM, 32'hAB);
        read_check("pwm_absent", ADDR_PWM, 32'h0);
        check("led_out_steady", 32'(led_out), 32'h155);
`endif

        // Reset in the middle of a debounce, switches held high across release
        sw_in[3] = 1'b1;
        step(5);
        rst_n = 1'b0;
        step(1);
        check("midreset_led_out", 32'(led_out), 32'h0);
        check("midreset_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;
        read_check("midreset_data", ADDR_DATA, 32'h0);
        bus_write(ADDR_IRQ_MASK, 32'h3FF);
        step(14);
        read_check("post_reset_data", ADDR_DATA, 32'h00E);
        read_check("post_reset_cap", ADDR_EDGE_CAPTURE, 32'h00E);
        check("post_reset_irq", 32'(irq), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
